gpio_pad_ctrl: RTL and testbench

//  Pad-side stage between the GPIO register block and the chip pins.

---
 rtl/gpio_pad_ctrl.sv | 121 ++++++++++++
 tb/tb_gpio_pad_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_pad_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : gpio_pad_ctrl                                               |
// | Function : GPIO pad stage - mode decode, input sync/debounce and       |
// |            sticky edge interrupts.                                     |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module gpio_pad_ctrl #(
  parameter int N_IO       = 16,
  parameter int DEB_CYCLES = 16,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2*N_IO-1:0] reg_ctrl,
  input  logic [31:0]       reg_data,
  input  logic [N_IO-1:0]   pad_i,
  output logic [N_IO-1:0]   pad_o,
  output logic [N_IO-1:0]   pad_oe,
  output logic [N_IO-1:0]   io_pin_o,
  input  logic [N_IO-1:0]   rise_en_i,
  input  logic [N_IO-1:0]   fall_en_i,
  input  logic [N_IO-1:0]   irq_clr_i,
  output logic [N_IO-1:0]   irq_pend_o,
  output logic              irq_o
);

  localparam logic [1:0]       MODE_OUT = 2'b01;
  localparam logic [1:0]       MODE_IN  = 2'b10;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [N_IO-1:0]  is_out, is_in;
  logic [N_IO-1:0]  pad_o_d, pad_o_q, pad_oe_d, pad_oe_q;
  logic [N_IO-1:0]  s1_d, s1_q, s2_d, s2_q;
  logic [N_IO-1:0]  deb_d, deb_q, deb_dly_d, deb_dly_q;
  logic [CNT_W-1:0] cnt_d [N_IO];
  logic [CNT_W-1:0] cnt_q [N_IO];
  logic [N_IO-1:0]  rise, fall, set;
  logic [N_IO-1:0]  pend_d, pend_q;
  logic             irq_d, irq_q;

  // Data bits above the pin count have no pad to drive.
  if (N_IO < 32) begin : g_data_unused
    logic unused_data;
    assign unused_data = ^reg_data[31:N_IO];
  end

  always_comb begin
    is_out   = '0;
    is_in    = '0;
    pad_oe_d = '0;
    pad_o_d  = '0;
    for (int i = 0; i < N_IO; i++) begin
      is_out[i]   = (reg_ctrl[2*i +: 2] == MODE_OUT);
      is_in[i]    = (reg_ctrl[2*i +: 2] == MODE_IN);
      pad_oe_d[i] = is_out[i];
      pad_o_d[i]  = reg_data[i] & is_out[i];
    end
  end

  always_comb begin
    s1_d  = pad_i;
    s2_d  = s1_q;
    deb_d = deb_q;
    cnt_d = cnt_q;
    for (int i = 0; i < N_IO; i++) begin
      if (s2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          deb_d[i] = s2_q[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end else begin
        cnt_d[i] = '0;
      end
    end
  end

  // Clear and set in the same cycle: the new event wins.
  always_comb begin
    deb_dly_d = deb_q;
    rise      = deb_q & ~deb_dly_q;
    fall      = ~deb_q & deb_dly_q;
    set       = is_in & ((rise & rise_en_i) | (fall & fall_en_i));
    pend_d    = set | (pend_q & ~irq_clr_i);
    irq_d     = |pend_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pad_o_q   <= '0;
      pad_oe_q  <= '0;
      s1_q      <= '0;
      s2_q      <= '0;
      deb_q     <= '0;
      deb_dly_q <= '0;
      cnt_q     <= '{default: '0};
      pend_q    <= '0;
      irq_q     <= 1'b0;
    end else begin
      pad_o_q   <= pad_o_d;
      pad_oe_q  <= pad_oe_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      deb_q     <= deb_d;
      deb_dly_q <= deb_dly_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      irq_q     <= irq_d;
    end
  end

  assign pad_o      = pad_o_q;
  assign pad_oe     = pad_oe_q;
  assign io_pin_o   = deb_q;
  assign irq_pend_o = pend_q;
  assign irq_o      = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_gpio_pad_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_gpio_pad_ctrl                                            |
// | Function : Self-checking bench for gpio_pad_ctrl (vectors, corner      |
// |            sequences and random traffic against a sliding-window model)|
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module tb_gpio_pad_ctrl;

  localparam int N   = 16;
  localparam int DEB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [2*N-1:0] reg_ctrl;
  logic [31:0]   reg_data;
  logic [N-1:0]  pad_i, pad_o, pad_oe, io_pin_o;
  logic [N-1:0]  rise_en_i, fall_en_i, irq_clr_i, irq_pend_o;
  logic          irq_o;

  int n_checks = 0;
  int n_errors = 0;

  gpio_pad_ctrl #(.N_IO(N), .DEB_CYCLES(DEB), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .reg_ctrl(reg_ctrl), .reg_data(reg_data),
    .pad_i(pad_i), .pad_o(pad_o), .pad_oe(pad_oe), .io_pin_o(io_pin_o),
    .rise_en_i(rise_en_i), .fall_en_i(fall_en_i), .irq_clr_i(irq_clr_i),
    .irq_pend_o(irq_pend_o), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  // Reference model: the debounced level flips once the last DEB synchronised
  // samples all agree on the opposite value; a flip is reported one edge later.
  logic [N-1:0] m_s1, m_s2, m_deb, m_pend, m_po, m_poe, m_rise, m_fall;
  logic         m_irq;
  logic [N-1:0] win[$];

  task automatic model_edge();
    logic [N-1:0] mode_in, mode_out, set_v, new_deb;
    bit all1, all0;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_deb = '0; m_pend = '0; m_irq = 1'b0;
      m_po = '0; m_poe = '0; m_rise = '0; m_fall = '0;
      win.delete();
    end else begin
      for (int i = 0; i < N; i++) begin
        mode_in[i]  = (reg_ctrl[2*i +: 2] == 2'b10);
        mode_out[i] = (reg_ctrl[2*i +: 2] == 2'b01);
      end
      set_v  = mode_in & ((m_rise & rise_en_i) | (m_fall & fall_en_i));
      m_pend = set_v | (m_pend & ~irq_clr_i);
      m_irq  = (m_pend != '0);
      win.push_back(m_s2);
      if (win.size() > DEB) void'(win.pop_front());
      new_deb = m_deb;
      if (win.size() == DEB) begin
        for (int i = 0; i < N; i++) begin
          all1 = 1'b1; all0 = 1'b1;
          for (int j = 0; j < DEB; j++) begin
            if (win[j][i]) all0 = 1'b0; else all1 = 1'b0;
          end
          if (all1) new_deb[i] = 1'b1;
          if (all0) new_deb[i] = 1'b0;
        end
      end
      m_rise = new_deb & ~m_deb;
      m_fall = ~new_deb & m_deb;
      m_deb  = new_deb;
      m_s2   = m_s1;
      m_s1   = pad_i;
      m_poe  = mode_out;
      m_po   = mode_out & reg_data[N-1:0];
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("model pad_o", 32'(pad_o), 32'(m_po));
    chk("model pad_oe", 32'(pad_oe), 32'(m_poe));
    chk("model io_pin_o", 32'(io_pin_o), 32'(m_deb));
    chk("model irq_pend_o", 32'(irq_pend_o), 32'(m_pend));
    chk("model irq_o", 32'(irq_o), 32'(m_irq));
  endtask

  task automatic step_n(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1; reg_ctrl = '0; reg_data = '0; pad_i = '0;
    rise_en_i = '0; fall_en_i = '0; irq_clr_i = '0;
    step_n(2);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [31:0] ctrl;
    logic [31:0] data;
    logic [N-1:0] exp_o;
    logic [N-1:0] exp_oe;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{32'h0000_0001, 32'h0000_0001, 16'h0001, 16'h0001};
    vecs[1] = '{32'h0000_0000, 32'h0000_FFFF, 16'h0000, 16'h0000};
    vecs[2] = '{32'h5555_5555, 32'h0000_A5A5, 16'hA5A5, 16'hFFFF};
    vecs[3] = '{32'hFFFF_FFFF, 32'h0000_FFFF, 16'h0000, 16'h0000};
    vecs[4] = '{32'hAAAA_AAAA, 32'h0000_FFFF, 16'h0000, 16'h0000};
    vecs[5] = '{32'h0000_0004, 32'h0000_0002, 16'h0002, 16'h0002};
    vecs[6] = '{32'h4000_0000, 32'hFFFF_0000, 16'h0000, 16'h8000};
    vecs[7] = '{32'h4000_0000, 32'h0000_8000, 16'h8000, 16'h8000};
    vecs[8] = '{32'h5555_5555, 32'hFFFF_0000, 16'h0000, 16'hFFFF};

    do_reset();
    chk("reset pad_o", 32'(pad_o), 0);
    chk("reset pad_oe", 32'(pad_oe), 0);
    chk("reset io_pin_o", 32'(io_pin_o), 0);
    chk("reset irq_pend_o", 32'(irq_pend_o), 0);
    chk("reset irq_o", 32'(irq_o), 0);

    // Output drive table
    foreach (vecs[v]) begin
      reg_ctrl = vecs[v].ctrl;
      reg_data = vecs[v].data;
      step();
      chk($sformatf("vec%0d pad_o", v), 32'(pad_o), 32'(vecs[v].exp_o));
      chk($sformatf("vec%0d pad_oe", v), 32'(pad_oe), 32'(vecs[v].exp_oe));
    end

    // Debounce latency, pin3 input, no rise enable
    do_reset();
    reg_ctrl = 32'h80; pad_i = 16'h0008;
    for (int e = 0; e <= 5; e++) begin
      step();
      chk($sformatf("deb_lat io3 edge%0d", e), 32'(io_pin_o[3]), (e >= 5) ? 1 : 0);
    end
    step_n(3);
    chk("deb_lat pend3", 32'(irq_pend_o[3]), 0);

    // Glitch reject: three high samples then low
    do_reset();
    reg_ctrl = 32'h80; rise_en_i = '1; fall_en_i = '1; pad_i = 16'h0008;
    step_n(3);
    pad_i = '0;
    for (int e = 0; e < 10; e++) begin
      step();
      chk("glitch io3", 32'(io_pin_o[3]), 0);
    end
    chk("glitch pend", 32'(irq_pend_o), 0);

    // Interrupts on pin5
    do_reset();
    reg_ctrl = 32'h800; fall_en_i = 16'h0020; pad_i = 16'h0020;
    step_n(8);
    chk("irq setup io5", 32'(io_pin_o[5]), 1);
    chk("irq setup pend", 32'(irq_pend_o), 0);
    pad_i = '0;
    for (int e = 0; e <= 5; e++) begin
      step();
      chk($sformatf("fall io5 edge%0d", e), 32'(io_pin_o[5]), (e >= 5) ? 0 : 1);
      chk("fall pend early", 32'(irq_pend_o), 0);
    end
    step();
    chk("fall pend", 32'(irq_pend_o), 32'h20);
    chk("fall irq", 32'(irq_o), 1);
    reg_ctrl = 32'h0;
    step();
    chk("hold pend after mode change", 32'(irq_pend_o), 32'h20);
    reg_ctrl = 32'h800; irq_clr_i = 16'h0020;
    step();
    irq_clr_i = '0;
    chk("clr pend", 32'(irq_pend_o), 0);
    chk("clr irq", 32'(irq_o), 0);
    pad_i = 16'h0020;
    step_n(8);
    chk("rise not enabled", 32'(irq_pend_o), 0);
    pad_i = '0;
    step_n(6);
    chk("pre-coincide pend", 32'(irq_pend_o), 0);
    irq_clr_i = 16'h0020;
    step();
    irq_clr_i = '0;
    chk("set wins pend", 32'(irq_pend_o), 32'h20);
    chk("set wins irq", 32'(irq_o), 1);
    step();
    chk("set wins hold", 32'(irq_pend_o), 32'h20);

    // Mode gating: pin7 in output mode
    do_reset();
    reg_ctrl = 32'h4000; rise_en_i = 16'h0080; pad_i = 16'h0080;
    step_n(10);
    chk("gate io7", 32'(io_pin_o[7]), 1);
    chk("gate pend7", 32'(irq_pend_o[7]), 0);
    chk("gate oe7", 32'(pad_oe), 32'h80);

    // Reset mid-debounce
    do_reset();
    reg_ctrl = 32'h81; reg_data = 32'h1; rise_en_i = 16'h0008; pad_i = 16'h0008;
    step_n(4);
    chk("pre-reset oe", 32'(pad_oe), 1);
    rst = 1'b1;
    step();
    chk("midrst pad_o", 32'(pad_o), 0);
    chk("midrst pad_oe", 32'(pad_oe), 0);
    chk("midrst io", 32'(io_pin_o), 0);
    chk("midrst pend", 32'(irq_pend_o), 0);
    chk("midrst irq", 32'(irq_o), 0);
    rst = 1'b0;
    for (int e = 0; e <= 5; e++) begin
      step();
      chk($sformatf("post-rst io3 edge%0d", e), 32'(io_pin_o[3]), (e >= 5) ? 1 : 0);
    end
    chk("post-rst pend early", 32'(irq_pend_o), 0);
    step();
    chk("post-rst pend3", 32'(irq_pend_o[3]), 1);
    chk("post-rst irq", 32'(irq_o), 1);

    // Random traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 63) == 0) reg_ctrl = $urandom;
      if ($urandom_range(0, 15) == 0) reg_data = $urandom;
      if ($urandom_range(0, 127) == 0) begin
        rise_en_i = N'($urandom);
        fall_en_i = N'($urandom);
      end
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 11) == 0) pad_i[i] = ~pad_i[i];
      irq_clr_i = N'($urandom & $urandom & $urandom);
      rst = ($urandom_range(0, 999) == 0);
      step();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
